// File: rtl/tcdm_write_combiner.sv
// Write-combining buffer between the narrow-to-wide converter and a wide TCDM bank.
// Holds one line, merges same-line writes by byte enable, and flushes before any read.
module tcdm_write_combiner #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  // upstream (from the width converter)
  input  logic                    master_port_req,
  output logic                    master_port_gnt,
  input  logic                    master_port_wen,
  input  logic [ADDR_WIDTH-1:0]   master_port_addr,
  input  logic [DATA_WIDTH/8-1:0] master_port_be,
  input  logic [DATA_WIDTH-1:0]   master_port_data,
  output logic [DATA_WIDTH-1:0]   master_port_r_data,
  output logic                    master_port_r_valid,
  input  logic                    master_port_r_ready,
  // downstream (toward the bank)
  output logic                    slave_port_req,
  input  logic                    slave_port_gnt,
  output logic                    slave_port_wen,
  output logic [ADDR_WIDTH-1:0]   slave_port_addr,
  output logic [DATA_WIDTH/8-1:0] slave_port_be,
  output logic [DATA_WIDTH-1:0]   slave_port_data,
  input  logic [DATA_WIDTH-1:0]   slave_port_r_data,
  input  logic                    slave_port_r_valid,
  output logic                    slave_port_r_ready,
  input  logic                    flush_i,
  output logic                    idle_o
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [BE_WIDTH-1:0]   buf_be_q;
  logic [DATA_WIDTH-1:0] buf_data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic load, merge, clear, cnt_clr, cnt_inc;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_data,
    input logic [DATA_WIDTH-1:0] new_data,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_data;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) res[i*8 +: 8] = new_data[i*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d         = state_q;
    load            = 1'b0;
    merge           = 1'b0;
    clear           = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    master_port_gnt = 1'b0;
    slave_port_req  = 1'b0;
    slave_port_wen  = master_port_wen;
    slave_port_addr = master_port_addr;
    slave_port_be   = master_port_be;
    slave_port_data = master_port_data;
    case (state_q)
      IDLE: begin
        if (master_port_req) begin
          if (master_port_wen) begin
            master_port_gnt = 1'b1;
            load            = 1'b1;
            cnt_clr         = 1'b1;
            state_d         = (TIMEOUT_CYCLES == 0) ? FLUSH : HOLD;
          end else begin
            slave_port_req  = 1'b1;
            master_port_gnt = slave_port_gnt;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          state_d = FLUSH;
        end else if (master_port_req && master_port_wen && master_port_addr == buf_addr_q) begin
          master_port_gnt = 1'b1;
          merge           = 1'b1;
          cnt_clr         = 1'b1;
          if (&(buf_be_q | master_port_be)) state_d = FLUSH;
        end else begin
          // Any other request (read or different line) must wait behind the flush.
          cnt_inc = 1'b1;
          if (master_port_req || cnt_q == CNT_LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        slave_port_req  = 1'b1;
        slave_port_wen  = 1'b1;
        slave_port_addr = buf_addr_q;
        slave_port_be   = buf_be_q;
        slave_port_data = buf_data_q;
        if (slave_port_gnt) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      buf_addr_q <= '0;
      buf_be_q   <= '0;
      buf_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        buf_addr_q <= master_port_addr;
        buf_be_q   <= master_port_be;
        buf_data_q <= master_port_data;
      end else if (merge) begin
        buf_be_q   <= buf_be_q | master_port_be;
        buf_data_q <= merge_bytes(buf_data_q, master_port_data, master_port_be);
      end else if (clear) begin
        buf_addr_q <= '0;
        buf_be_q   <= '0;
        buf_data_q <= '0;
      end
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign master_port_r_data  = slave_port_r_data;
  assign master_port_r_valid = slave_port_r_valid;
  assign slave_port_r_ready  = master_port_r_ready;
  assign idle_o              = (state_q == IDLE);

endmodule

// File: tb/tb_tcdm_write_combiner.sv
// Randomized and directed bench for tcdm_write_combiner with a line-level reference model.
module tb_tcdm_write_combiner;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int BW = 16;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m_req, m_gnt, m_wen, m_r_valid, m_r_ready;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_data, m_r_data;
  logic          s_req, s_gnt, s_wen, s_r_valid, s_r_ready;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_be;
  logic [DW-1:0] s_data, s_r_data;
  logic          flush, idle;

  tcdm_write_combiner #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .master_port_req(m_req), .master_port_gnt(m_gnt), .master_port_wen(m_wen),
    .master_port_addr(m_addr), .master_port_be(m_be), .master_port_data(m_data),
    .master_port_r_data(m_r_data), .master_port_r_valid(m_r_valid), .master_port_r_ready(m_r_ready),
    .slave_port_req(s_req), .slave_port_gnt(s_gnt), .slave_port_wen(s_wen),
    .slave_port_addr(s_addr), .slave_port_be(s_be), .slave_port_data(s_data),
    .slave_port_r_data(s_r_data), .slave_port_r_valid(s_r_valid), .slave_port_r_ready(s_r_ready),
    .flush_i(flush), .idle_o(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one pending line with an absolute flush deadline.
  bit           md_valid, md_flushing;
  logic [31:0]  md_addr;
  logic [15:0]  md_be;
  logic [127:0] md_data;
  int           md_deadline;
  logic [127:0] model_mem [logic [31:0]];
  logic [127:0] bank_mem  [logic [31:0]];
  logic [127:0] rsp_q [$];

  // Bank behaviour and observations.
  logic         bank_rv_nxt = 1'b0;
  logic [127:0] bank_rd_nxt = '0;
  int           gnt_mode = 0;
  bit           flush_rand = 0;
  bit           rand_rready = 0;
  int           last_mgnt_wr_cyc, flush_start_cyc, flush_gnt_cyc, read_fwd_cyc;
  logic [31:0]  last_wr_addr;
  logic [15:0]  last_wr_be;
  logic [127:0] last_wr_data, last_rsp_data;
  int           wr_count = 0;
  bit           prev_sreq_wr = 0;

  function automatic logic [127:0] be_mask(input logic [15:0] be);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare, model update and bank at the falling edge.
  initial forever begin
    logic e_gnt, e_sreq;
    logic [127:0] mk, rd;
    @(negedge clk);
    cyc++;
    if (!resetn) begin
      md_valid = 0; md_flushing = 0; rsp_q.delete();
      bank_rv_nxt = 1'b0; prev_sreq_wr = 0;
    end else begin
      e_gnt = 1'b0; e_sreq = 1'b0;
      check("idle_o", idle, !md_valid);
      check("r_valid_pass", m_r_valid, s_r_valid);
      if (s_r_valid) check("r_data_pass", m_r_data, s_r_data);
      check("r_ready_pass", s_r_ready, m_r_ready);
      if (m_r_valid) begin
        last_rsp_data = m_r_data;
        if (rsp_q.size() == 0) check("unexpected_rsp", 1'b1, 1'b0);
        else begin rd = rsp_q.pop_front(); check("rsp_data", m_r_data, rd); end
      end
      if (!md_valid) begin
        if (m_req && m_wen) begin
          e_gnt = 1'b1;
          md_valid = 1; md_flushing = (T == 0);
          md_addr = m_addr; md_be = m_be; md_data = m_data;
          md_deadline = cyc + 1 + T;
        end else if (m_req) begin
          e_sreq = 1'b1; e_gnt = s_gnt;
          check("rd_addr", s_addr, m_addr);
          check("rd_wen", s_wen, 1'b0);
          if (s_gnt) begin
            rsp_q.push_back(model_mem.exists(m_addr) ? model_mem[m_addr] : 128'h0);
            read_fwd_cyc = cyc;
          end
        end
      end else if (md_flushing) begin
        e_sreq = 1'b1;
        mk = be_mask(md_be);
        check("fl_wen", s_wen, 1'b1);
        check("fl_addr", s_addr, md_addr);
        check("fl_be", s_be, md_be);
        check("fl_data", s_data & mk, md_data & mk);
        if (s_gnt) begin
          rd = model_mem.exists(md_addr) ? model_mem[md_addr] : 128'h0;
          model_mem[md_addr] = (rd & ~mk) | (md_data & mk);
          md_valid = 0; md_flushing = 0;
        end
      end else begin
        if (flush) md_flushing = 1;
        else if (m_req && m_wen && m_addr == md_addr) begin
          e_gnt = 1'b1;
          mk = be_mask(m_be);
          md_data = (md_data & ~mk) | (m_data & mk);
          md_be = md_be | m_be;
          md_deadline = cyc + 1 + T;
          if (md_be == 16'hFFFF) md_flushing = 1;
        end else if (m_req) md_flushing = 1;
        else if (cyc + 1 >= md_deadline) md_flushing = 1;
      end
      check("m_gnt", m_gnt, e_gnt);
      check("s_req", s_req, e_sreq);
      if (m_req && m_wen && m_gnt) last_mgnt_wr_cyc = cyc;
      if (s_req && s_wen && !prev_sreq_wr) flush_start_cyc = cyc;
      prev_sreq_wr = s_req && s_wen;
      bank_rv_nxt = 1'b0;
      if (s_req && s_gnt) begin
        rd = bank_mem.exists(s_addr) ? bank_mem[s_addr] : 128'h0;
        if (s_wen) begin
          mk = be_mask(s_be);
          bank_mem[s_addr] = (rd & ~mk) | (s_data & mk);
          last_wr_addr = s_addr; last_wr_be = s_be; last_wr_data = s_data;
          wr_count++; flush_gnt_cyc = cyc;
        end else begin
          bank_rv_nxt = 1'b1; bank_rd_nxt = rd;
        end
      end
    end
  end

  // Background drivers: bank grant/response, random flush and r_ready.
  initial forever begin
    @(posedge clk); #1;
    s_r_valid = bank_rv_nxt;
    s_r_data  = bank_rd_nxt;
    case (gnt_mode)
      0: s_gnt = 1'b1;
      1: s_gnt = ($urandom_range(0, 3) != 0);
      default: s_gnt = 1'b0;
    endcase
    flush = flush_rand && ($urandom_range(0, 19) == 0);
    if (rand_rready) m_r_ready = $urandom_range(0, 1) != 0;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_req(input logic wen, input logic [31:0] a, input logic [15:0] be,
                        input logic [127:0] d, output int lat);
    m_req = 1'b1; m_wen = wen; m_addr = a; m_be = be; m_data = d; lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (m_gnt) break;
      if (lat > 300) begin
        checks++; errors++;
        $display("FAIL req_timeout: addr %h no gnt after %0d cycles", a, lat);
        break;
      end
    end
    @(posedge clk); #1;
    m_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, acc, wc;
    logic [127:0] d;
    logic [31:0] w;
    resetn = 1'b0; m_req = 0; m_wen = 0; m_addr = '0; m_be = '0; m_data = '0; m_r_ready = 1'b1;
    s_gnt = 1'b1; s_r_valid = 1'b0; s_r_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", idle, 1'b1);
    check("rst_sreq", s_req, 1'b0);
    check("rst_mgnt", m_gnt, 1'b0);
    resetn = 1'b1;
    idle_cycles(2);

    // Four lane writes to one line merge into a full-line write.
    for (int i = 0; i < 4; i++) begin
      d = {4{32'hDEADBEEF}};
      d[i*32 +: 32] = 32'hCAFE0000 + i;
      do_req(1'b1, 32'h100, 16'h000F << (4 * i), d, lat);
      check("merge_lat", lat, 1);
    end
    acc = last_mgnt_wr_cyc;
    idle_cycles(3);
    check("full_req_cyc", flush_start_cyc, acc + 1);
    check("full_addr", last_wr_addr, 32'h100);
    check("full_be", last_wr_be, 16'hFFFF);
    check("full_data", last_wr_data, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);

    // Timeout flush.
    do_req(1'b1, 32'h200, 16'h000F, {96'h0, 32'h22220001}, lat);
    acc = last_mgnt_wr_cyc;
    idle_cycles(25);
    check("to_req_cyc", flush_start_cyc, acc + 17);
    check("to_addr", last_wr_addr, 32'h200);
    check("to_be", last_wr_be, 16'h000F);
    w = last_wr_data[31:0];
    check("to_data", w, 32'h22220001);

    // Overwrite of the same lane keeps the newest data.
    wc = wr_count;
    do_req(1'b1, 32'h300, 16'h000F, {96'h0, 32'hAAAA0000}, lat);
    do_req(1'b1, 32'h300, 16'h000F, {96'h0, 32'hBBBB0000}, lat);
    idle_cycles(25);
    check("ovw_count", wr_count, wc + 1);
    w = last_wr_data[31:0];
    check("ovw_data", w, 32'hBBBB0000);

    // Conflicting line forces a flush before acceptance.
    do_req(1'b1, 32'h400, 16'h00F0, {4{32'h44444444}}, lat);
    do_req(1'b1, 32'h500, 16'h0F00, {4{32'h55555555}}, lat);
    acc = last_mgnt_wr_cyc;
    check("conf_held", lat > 1, 1'b1);
    check("conf_accept_cyc", acc, flush_gnt_cyc + 1);
    check("conf_first_addr", last_wr_addr, 32'h400);
    idle_cycles(25);
    check("conf_second_addr", last_wr_addr, 32'h500);
    check("conf_second_cyc", flush_start_cyc, acc + 17);

    // Read behind a pending line, with the flush stalled downstream.
    gnt_mode = 2;
    idle_cycles(1);
    do_req(1'b1, 32'h600, 16'h000F, {96'h0, 32'h66660006}, lat);
    fork
      do_req(1'b0, 32'h600, 16'h0000, 128'h0, lat);
      begin repeat (4) @(posedge clk); gnt_mode = 0; end
    join
    idle_cycles(2);
    check("rd_stalled", lat > 1, 1'b1);
    check("rd_stall_len", flush_gnt_cyc, flush_start_cyc + 3);
    check("rd_after_flush", read_fwd_cyc, flush_gnt_cyc + 1);
    w = last_rsp_data[31:0];
    check("rd_data", w, 32'h66660006);

    // Reset while a line is pending discards it.
    do_req(1'b1, 32'h700, 16'h000F, {96'h0, 32'h77770007}, lat);
    idle_cycles(2);
    wc = wr_count;
    resetn = 1'b0;
    #1;
    check("rst_mid_sreq", s_req, 1'b0);
    check("rst_mid_idle", idle, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    idle_cycles(30);
    check("rst_no_write", wr_count, wc);

    // Randomized traffic checked against the model every cycle.
    gnt_mode = 1; flush_rand = 1; rand_rready = 1;
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [31:0] a;
      logic [15:0] be;
      r = $urandom_range(0, 99);
      a = 32'h1000 + 32'(16 * $urandom_range(0, 2));
      if ($urandom_range(0, 1) != 0) be = 16'h000F << (4 * $urandom_range(0, 3));
      else be = 16'($urandom_range(1, 65535));
      d = {$urandom, $urandom, $urandom, $urandom};
      if (r < 60) do_req(1'b1, a, be, d, lat);
      else if (r < 80) do_req(1'b0, a, 16'h0, 128'h0, lat);
      else idle_cycles($urandom_range(1, 20));
    end
    flush_rand = 0; rand_rready = 0; gnt_mode = 0; m_r_ready = 1'b1;
    idle_cycles(40);
    check("end_idle", idle, 1'b1);
    check("end_rsp_drained", rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tcdm_write_combiner.md
# tcdm_write_combiner

Write-combining stage between the narrow-to-wide data width converter and the wide TCDM bank. The converter turns each narrow write into a full-width write with a single sub-word byte-enable lane. This block holds one wide line, merges successive writes to the same line by byte-enable, and issues one wide write per line. Reads pass through after any pending line has been written out, which keeps memory order intact.

## Interface
Parameters:
- DATA_WIDTH, 128, wide data width in bits; a multiple of 8.
- ADDR_WIDTH, 32, address width; addresses arrive aligned to DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, idle HOLD cycles before an automatic flush; 0 disables combining.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- resetn_i  input  1  reset; asynchronous, active-low.
- master_port  mem_intf.slave  DATA_WIDTH  upstream side (from the width converter): req, gnt, wen (1 = write), addr, be, data, r_data, r_valid, r_ready.
- slave_port  mem_intf.master  DATA_WIDTH  downstream side (toward the bank), same signal set.
- flush_i  input  1  forces a pending line to be written out (fence).
- idle_o  output  1  high when the buffer is empty and the FSM is in IDLE.

## Operation
- Registered state:
  - buffer: buf_addr, buf_be, buf_data.
  - FSM state: IDLE, HOLD or FLUSH.
  - timer cnt, width $clog2(TIMEOUT_CYCLES+1).
- IDLE (buffer empty):
  - Write request: gnt=1. Load addr/be/data, cnt<=0, next state HOLD. If TIMEOUT_CYCLES==0, next state is FLUSH.
  - Read request: pass through combinationally. slave req/addr/wen/be/data = master values; master gnt = slave gnt.
- HOLD (buffer valid):
  - Write with addr==buf_addr: gnt=1.
    - Merge per byte: lanes with be=1 take the new data; buf_be |= be.
    - cnt<=0.
    - Next state FLUSH if the merged buf_be is all ones, otherwise stay in HOLD.
  - Write to a different addr, or any read: gnt=0, next state FLUSH.
  - No accepted write: cnt<=cnt+1. When cnt==TIMEOUT_CYCLES-1, next state FLUSH.
  - flush_i=1: next state FLUSH. In that cycle, gnt=0 for all requests.
- FLUSH:
  - slave req=1, wen=1, addr=buf_addr, be=buf_be, data=buf_data. All driven from registers.
  - Master gnt=0.
  - On slave gnt, next state IDLE and the buffer is cleared.
- Read response channel is a pure pass-through in every state: master r_data/r_valid = slave r_data/r_valid; slave r_ready = master r_ready.
- Outside FLUSH and outside the IDLE read pass-through, slave req=0.
- Ordering rules:
  - No read is issued downstream while the buffer holds data.
  - Writes never bypass a flush.
  - Downstream responses are in order, so an outstanding read response does not block flushes.

## Timing
- Reset values:
  - FSM=IDLE; buffer, buf_be and cnt cleared.
  - slave req=0; master gnt=0 when req=0; idle_o=1.
  - Reset mid-operation discards any pending line; it is never written.
- Write accept latency: 0 cycles (gnt in the request cycle) in IDLE, and in HOLD for a same-line write.
- Timeout: last write accepted at edge t → slave req asserted in cycle t+1+TIMEOUT_CYCLES, provided no further write to the line arrives.
- Full-line or conflict trigger at edge t → slave req asserted in cycle t+1 and held until gnt.
- Read behind a pending line: the read gnt can come at the earliest in the cycle after the flush gnt (flush gnt at edge f → read is forwarded in cycle f+1).
- Simultaneous events in HOLD: a same-line write and flush_i → flush_i wins, the write is not granted. A same-line write and timeout expiry → the write wins, it merges and cnt resets.
- flush_i in IDLE has no effect. flush_i in FLUSH has no effect.
- Downstream gnt stalls extend FLUSH indefinitely. All buffer registers stay stable throughout.

## Test plan
- Four writes to addr 0x100 with be 0x000F, 0x00F0, 0x0F00, 0xF000 on consecutive cycles → each granted at 0 latency; one downstream write to 0x100 with be=0xFFFF and all four words merged, req in the cycle after the 4th accept.
- Write 0x200 be=0x000F, then no traffic, TIMEOUT_CYCLES=16 → downstream write at 0x200 be=0x000F asserted exactly 17 cycles after the accept edge.
- Write 0x300 data word0=A, then write 0x300 word0=B (be 0x000F) → single downstream write with word0=B.
- Write 0x400, then write 0x500 → the 0x500 gnt is held low. Downstream 0x400 write is followed by the 0x500 accept one cycle after the flush gnt. A later timeout flushes 0x500.
- Write 0x600, then read 0x600 with downstream gnt stalled 3 cycles → read not forwarded before the write is granted; the read returns the merged data through r_valid pass-through.
- Assert resetn_i low while in HOLD with 0x700 pending → no downstream write ever occurs. idle_o=1 and slave req=0 immediately on reset assertion.
